// File: rtl/fifo_put_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with bursts capped at MAX_BURST beats per grant and a one-cycle arbitration bubble.
module fifo_put_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = 2,
    parameter int CNT_W     = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] data_in,
    input  logic                     fifo_full,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     fifo_put,
    output logic [WIDTH-1:0]         fifo_data,
    output logic [ID_W-1:0]          owner_id,
    output logic [CNT_W-1:0]         beat_cnt
);

    // Handshake: a producer holds req[i] and its word stable until ack[i] is seen
    // high at a rising edge; dropping req[i] without an ack withdraws the request.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [ID_W-1:0] rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    logic            busy;
    logic            owner_req;
    logic            last_beat;

    assign busy      = (state_q == ST_BUSY);
    assign owner_req = req[owner_q];
    assign last_beat = (cnt_q == CNT_W'(MAX_BURST - 1));

    // Descending scan so the requester closest to rr_q overwrites the others.
    always_comb begin
        pick = rr_q;
        idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_q) + k) % NUM_REQ);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

    always_comb begin
        fifo_put  = busy & owner_req & ~fifo_full;
        grant     = busy ? (NUM_REQ'(1) << owner_q) : '0;
        ack       = fifo_put ? (NUM_REQ'(1) << owner_q) : '0;
        fifo_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (busy && (owner_q == ID_W'(k))) begin
                fifo_data = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req != '0) begin
                    state_d = ST_BUSY;
                    owner_d = pick;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (!owner_req || (fifo_put && last_beat)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rr_d    = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);
                end else if (fifo_put) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign owner_id = owner_q;
    assign beat_cnt = cnt_q;

endmodule
